// File: rtl/tag_stream_generator.sv
// Multi-lane time-tag source for self-test of the counting/histogram chain.
// Emits monotonic timestamps, valids and channels derived from per-lane Galois LFSRs.
module tag_stream_generator #(
    parameter int          TAG_WIDTH       = 64,
    parameter int          NUM_OF_TAGS     = 4,
    parameter int          CHANNEL_WIDTH   = 6,
    parameter int          NUM_OF_CHANNELS = 4,
    parameter int          INTERVAL_WIDTH  = 16,
    parameter logic [31:0] SEED            = 32'h1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic                                 pause,
    input  logic                                 dense,
    input  logic [TAG_WIDTH-1:0]                 start_time,
    input  logic [INTERVAL_WIDTH-1:0]            min_interval,
    input  logic [INTERVAL_WIDTH-1:0]            interval_mask,
    input  logic [31:0]                          num_tags,
    output logic [NUM_OF_TAGS-1:0]               valid_tag,
    output logic [TAG_WIDTH*NUM_OF_TAGS-1:0]     tagtime,
    output logic [CHANNEL_WIDTH*NUM_OF_TAGS-1:0] channel,
    output logic                                 busy,
    output logic                                 done,
    output logic [31:0]                          tags_sent,
    output logic [1:0]                           o_dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                           r_state;
    logic [31:0]                          r_lfsr [NUM_OF_TAGS];
    logic [TAG_WIDTH-1:0]                 r_base;
    logic [NUM_OF_TAGS-1:0]               r_valid;
    logic [TAG_WIDTH*NUM_OF_TAGS-1:0]     r_tagtime;
    logic [CHANNEL_WIDTH*NUM_OF_TAGS-1:0] r_channel;
    logic                                 r_done;
    logic [31:0]                          r_sent;

    logic [INTERVAL_WIDTH:0]              w_step [NUM_OF_TAGS];
    logic [TAG_WIDTH-1:0]                 w_time [NUM_OF_TAGS];
    logic [31:0]                          w_lfsr_next [NUM_OF_TAGS];
    logic [TAG_WIDTH-1:0]                 w_acc;
    logic [NUM_OF_TAGS-1:0]               w_cand;
    logic [NUM_OF_TAGS-1:0]               w_keep;
    logic [32:0]                          w_cnt;
    logic [32:0]                          w_kept;
    logic [32:0]                          w_rem;
    logic [32:0]                          w_sum;
    logic                                 w_limit;
    logic [31:0]                          w_sent_next;
    logic [TAG_WIDTH*NUM_OF_TAGS-1:0]     w_tagtime;
    logic [CHANNEL_WIDTH*NUM_OF_TAGS-1:0] w_channel;

    function automatic logic [31:0] lane_seed(input int lane);
        logic [31:0] v;
        v = SEED ^ (32'(lane + 1) * 32'h9E3779B9);
        return (v == 32'h0) ? 32'h1 : v;
    endfunction

    // Galois form of x^32+x^22+x^2+x+1, shifting right.
    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    always_comb begin
        w_acc     = r_base;
        w_cnt     = '0;
        w_kept    = '0;
        w_keep    = '0;
        w_cand    = '0;
        w_tagtime = '0;
        w_channel = '0;
        w_rem     = (num_tags > r_sent) ? {1'b0, num_tags - r_sent} : 33'd0;
        for (int i = 0; i < NUM_OF_TAGS; i++) begin
            w_step[i] = {1'b0, min_interval} + {1'b0, r_lfsr[i][INTERVAL_WIDTH-1:0] & interval_mask};
            if (w_step[i] == '0) begin
                w_step[i] = (INTERVAL_WIDTH+1)'(1);
            end
            w_acc          = w_acc + TAG_WIDTH'(w_step[i]);
            w_time[i]      = w_acc;
            w_cand[i]      = dense | r_lfsr[i][31];
            w_cnt          = w_cnt + 33'(w_cand[i]);
            w_lfsr_next[i] = lfsr_step(r_lfsr[i]);
        end
        w_limit = (num_tags != 32'h0) && (({1'b0, r_sent} + w_cnt) >= {1'b0, num_tags});
        // At the limit only the lowest-index candidates that fill the quota survive.
        for (int i = 0; i < NUM_OF_TAGS; i++) begin
            if (w_cand[i] && (!w_limit || (w_kept < w_rem))) begin
                w_keep[i] = 1'b1;
                w_kept    = w_kept + 33'd1;
                w_tagtime[i*TAG_WIDTH +: TAG_WIDTH]         = w_time[i];
                w_channel[i*CHANNEL_WIDTH +: CHANNEL_WIDTH] =
                    r_lfsr[i][CHANNEL_WIDTH+7:8] & CHANNEL_WIDTH'(NUM_OF_CHANNELS-1);
            end
        end
        w_sum       = {1'b0, r_sent} + w_kept;
        w_sent_next = w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_valid   <= '0;
            r_tagtime <= '0;
            r_channel <= '0;
            r_done    <= 1'b0;
            r_sent    <= '0;
            for (int i = 0; i < NUM_OF_TAGS; i++) begin
                r_lfsr[i] <= lane_seed(i);
            end
        end else begin
            r_valid   <= '0;
            r_tagtime <= '0;
            r_channel <= '0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_base  <= start_time;
                        r_sent  <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (!pause) begin
                        r_valid   <= w_keep;
                        r_tagtime <= w_tagtime;
                        r_channel <= w_channel;
                        r_base    <= w_acc;
                        r_sent    <= w_sent_next;
                        for (int i = 0; i < NUM_OF_TAGS; i++) begin
                            r_lfsr[i] <= w_lfsr_next[i];
                        end
                        if (w_limit) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= !abort;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign valid_tag   = r_valid;
    assign tagtime     = r_tagtime;
    assign channel     = r_channel;
    assign busy        = (r_state == S_RUN);
    assign done        = r_done;
    assign tags_sent   = r_sent;
    assign o_dbg_state = r_state;

endmodule
